cnn_frame_sequencer: RTL and testbench

//  Frame-level controller between the input row parallelizer and cnn_top.
//  - Gates the input row handshake into cnn_top.
//  - Counts input rows and drives in_row_last on the final row of each frame.
//  - Snoops the cnn_top -> serializer result handshake to retire frames.
//  - Limits frames in flight to MAX_INFLIGHT and flags result-framing errors.

---
 rtl/cnn_seq_pkg.sv | 21 ++
 rtl/frame_row_counter.sv | 29 ++
 rtl/cnn_frame_sequencer.sv | 159 +++++++++++++++
 tb/tb_cnn_frame_sequencer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_seq_pkg.sv
// Shared types and default frame geometry for the CNN frame sequencer.
// The default row counts are also used by the board-level top.
package cnn_seq_pkg;

  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_FEED = 2'd1,
    SEQ_FULL = 2'd2
  } seq_state_e;

  localparam int DEF_IN_ROWS      = 28;
  localparam int DEF_OUT_ROWS     = 1;
  localparam int DEF_MAX_INFLIGHT = 2;
  localparam int DEF_CNT_BITS     = 16;

  // Width of a counter that runs 0 .. max-1 (at least one bit)
  function automatic int cnt_width(input int max);
    return (max > 1) ? $clog2(max) : 1;
  endfunction

endpackage

// File: rtl/frame_row_counter.sv
// Wrapping row counter: counts 0 .. MAX-1 on inc_i, then wraps to 0.
// term_o flags the final row position so the caller can close a frame.
module frame_row_counter
  import cnn_seq_pkg::*;
#(
  parameter  int MAX = DEF_IN_ROWS,
  localparam int W   = cnt_width(MAX)
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         inc_i,
  output logic [W-1:0] count_o,
  output logic         term_o
);

  localparam logic [W-1:0] LAST = W'(MAX - 1);

  assign term_o = (count_o == LAST);

  // Advance on each increment, wrapping after the last row
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_o <= '0;
    end else if (inc_i) begin
      count_o <= term_o ? '0 : count_o + 1'b1;
    end
  end

endmodule

// File: rtl/cnn_frame_sequencer.sv
// Frame-level controller between the row parallelizer and cnn_top.
// Gates input rows, marks the last row of each frame, snoops the result
// handshake to retire frames, bounds frames in flight and flags result
// framing errors.
// Optional build macro FRAME_SEQ_STATS_EN adds saturating stall/busy
// cycle counters as extra output ports.
module cnn_frame_sequencer
  import cnn_seq_pkg::*;
#(
  parameter  int IN_ROWS      = DEF_IN_ROWS,
  parameter  int OUT_ROWS     = DEF_OUT_ROWS,
  parameter  int MAX_INFLIGHT = DEF_MAX_INFLIGHT,
  parameter  int CNT_BITS     = DEF_CNT_BITS,
  localparam int IW           = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                enable_i,
  input  logic                err_clr_i,
  input  logic                src_row_valid_i,
  output logic                src_row_accept_o,
  output logic                cnn_row_valid_o,
  input  logic                cnn_row_accept_i,
  output logic                cnn_row_last_o,
  input  logic                res_row_valid_i,
  input  logic                res_row_accept_i,
  input  logic                res_row_last_i,
  output logic                busy_o,
  output logic [IW-1:0]       inflight_o,
  output logic [CNT_BITS-1:0] frames_done_o,
  output logic                err_o
`ifdef FRAME_SEQ_STATS_EN
  ,
  output logic [CNT_BITS-1:0] stall_cycles_o,
  output logic [CNT_BITS-1:0] busy_cycles_o
`endif
);

  localparam logic [IW-1:0] MAX_IF = IW'(MAX_INFLIGHT);
  localparam int            IN_W   = cnt_width(IN_ROWS);
  localparam int            OUT_W  = cnt_width(OUT_ROWS);

  seq_state_e state, state_nxt;

  logic             gate;
  logic             in_xfer;
  logic             res_xfer;
  logic             in_term;
  logic             out_term;
  logic             out_inc;
  logic             underflow;
  logic             commit;
  logic             retire;
  logic             frame_err;
  logic [IW-1:0]    inflight_nxt;
  logic [IN_W-1:0]  in_cnt;
  logic [OUT_W-1:0] out_cnt;

  // Rows only flow while a frame is open, or when a new one may start
  assign gate = (state == SEQ_FEED) ||
                ((state == SEQ_IDLE) && enable_i && (inflight_o < MAX_IF));

  assign cnn_row_valid_o  = src_row_valid_i & gate;
  assign src_row_accept_o = cnn_row_accept_i & gate;
  assign in_xfer          = cnn_row_valid_o & cnn_row_accept_i;
  assign cnn_row_last_o   = gate & in_term;

  // A result with nothing in flight is an error and must not move counters
  assign res_xfer  = res_row_valid_i & res_row_accept_i;
  assign underflow = (inflight_o == '0);
  assign out_inc   = res_xfer & ~underflow;
  assign commit    = in_xfer & in_term;
  assign retire    = out_inc & out_term;
  assign frame_err = res_xfer & ((res_row_last_i != out_term) | underflow);

  assign busy_o = (state != SEQ_IDLE) || (inflight_o != '0);

  frame_row_counter #(.MAX(IN_ROWS)) u_in_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .inc_i   (in_xfer),
    .count_o (in_cnt),
    .term_o  (in_term)
  );

  frame_row_counter #(.MAX(OUT_ROWS)) u_out_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .inc_i   (out_inc),
    .count_o (out_cnt),
    .term_o  (out_term)
  );

  // Next in-flight count: commit and retire in one cycle cancel out
  always_comb begin
    inflight_nxt = inflight_o;
    case ({commit, retire})
      2'b10:   inflight_nxt = inflight_o + 1'b1;
      2'b01:   inflight_nxt = inflight_o - 1'b1;
      default: inflight_nxt = inflight_o;
    endcase
  end

  // Frame FSM next state: a last-row transfer closes the frame from any state
  always_comb begin
    state_nxt = state;
    if (commit) begin
      state_nxt = (inflight_nxt == MAX_IF) ? SEQ_FULL : SEQ_IDLE;
    end else begin
      case (state)
        SEQ_IDLE: if (in_xfer) state_nxt = SEQ_FEED;
        SEQ_FEED: state_nxt = SEQ_FEED;
        SEQ_FULL: if (inflight_o < MAX_IF) state_nxt = SEQ_IDLE;
        default:  state_nxt = SEQ_IDLE;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= SEQ_IDLE;
    else          state <= state_nxt;
  end

  // Frame accounting: in-flight count and wrapping retired-frame count
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      inflight_o    <= '0;
      frames_done_o <= '0;
    end else begin
      inflight_o <= inflight_nxt;
      if (retire) frames_done_o <= frames_done_o + 1'b1;
    end
  end

  // Sticky framing error; a fresh error outranks a clear in the same cycle
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)       err_o <= 1'b0;
    else if (frame_err) err_o <= 1'b1;
    else if (err_clr_i) err_o <= 1'b0;
  end

`ifdef FRAME_SEQ_STATS_EN
  logic stall_now;
  assign stall_now = src_row_valid_i & ~src_row_accept_o;

  // Saturating statistics counters
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_cycles_o <= '0;
      busy_cycles_o  <= '0;
    end else begin
      if (stall_now && (stall_cycles_o != '1)) stall_cycles_o <= stall_cycles_o + 1'b1;
      if (busy_o && (busy_cycles_o != '1))     busy_cycles_o  <= busy_cycles_o + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_cnn_frame_sequencer.sv
// Directed self-checking bench for cnn_frame_sequencer.
// u_dut uses default geometry; u_dut2 uses IN_ROWS=2, OUT_ROWS=2 for the
// result-framing error scenarios.
module tb_cnn_frame_sequencer;
  import cnn_seq_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;

  // Default-geometry instance signals
  logic        enable, err_clr, src_valid, cnn_accept;
  logic        res_valid, res_accept, res_last;
  logic        src_accept, cnn_valid, cnn_last, busy, err;
  logic [1:0]  inflight;
  logic [15:0] frames_done;

  // OUT_ROWS=2 instance signals
  logic        enable2, err_clr2, src_valid2, cnn_accept2;
  logic        res_valid2, res_accept2, res_last2;
  logic        src_accept2, cnn_valid2, cnn_last2, busy2, err2;
  logic [1:0]  inflight2;
  logic [15:0] frames_done2;

`ifdef FRAME_SEQ_STATS_EN
  logic [15:0] stall_cyc, busy_cyc, stall_cyc2, busy_cyc2;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int n_last;

  cnn_frame_sequencer u_dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .enable_i         (enable),
    .err_clr_i        (err_clr),
    .src_row_valid_i  (src_valid),
    .src_row_accept_o (src_accept),
    .cnn_row_valid_o  (cnn_valid),
    .cnn_row_accept_i (cnn_accept),
    .cnn_row_last_o   (cnn_last),
    .res_row_valid_i  (res_valid),
    .res_row_accept_i (res_accept),
    .res_row_last_i   (res_last),
    .busy_o           (busy),
    .inflight_o       (inflight),
    .frames_done_o    (frames_done),
    .err_o            (err)
`ifdef FRAME_SEQ_STATS_EN
    ,
    .stall_cycles_o   (stall_cyc),
    .busy_cycles_o    (busy_cyc)
`endif
  );

  cnn_frame_sequencer #(.IN_ROWS(2), .OUT_ROWS(2)) u_dut2 (
    .clock            (clock),
    .reset_n          (reset_n),
    .enable_i         (enable2),
    .err_clr_i        (err_clr2),
    .src_row_valid_i  (src_valid2),
    .src_row_accept_o (src_accept2),
    .cnn_row_valid_o  (cnn_valid2),
    .cnn_row_accept_i (cnn_accept2),
    .cnn_row_last_o   (cnn_last2),
    .res_row_valid_i  (res_valid2),
    .res_row_accept_i (res_accept2),
    .res_row_last_i   (res_last2),
    .busy_o           (busy2),
    .inflight_o       (inflight2),
    .frames_done_o    (frames_done2),
    .err_o            (err2)
`ifdef FRAME_SEQ_STATS_EN
    ,
    .stall_cycles_o   (stall_cyc2),
    .busy_cycles_o    (busy_cyc2)
`endif
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 unit after the edge
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Stream one full default frame; optionally retire a frame on the last row
  // and optionally drop enable after row drop_at.
  task automatic send_frame(input string tag, input bit retire_on_last, input int drop_at);
    n_last = 0;
    src_valid = 1'b1;
    for (int r = 1; r <= 28; r++) begin
      if (cnn_last) n_last++;
      if (r == 28) begin
        check({tag, "_last_row28"}, cnn_last, 1'b1);
        if (retire_on_last) begin
          res_valid = 1'b1; res_accept = 1'b1; res_last = 1'b1;
        end
      end
      tick();
      res_valid = 1'b0;
      if (r == drop_at) enable = 1'b0;
    end
    src_valid = 1'b0;
    check({tag, "_last_count"}, n_last, 1);
  endtask

  task automatic pulse_result();
    res_valid = 1'b1; res_accept = 1'b1; res_last = 1'b1;
    tick();
    res_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    enable = 0; err_clr = 0; src_valid = 0; cnn_accept = 1;
    res_valid = 0; res_accept = 0; res_last = 0;
    enable2 = 0; err_clr2 = 0; src_valid2 = 0; cnn_accept2 = 1;
    res_valid2 = 0; res_accept2 = 0; res_last2 = 0;

    // Reset state
    #3;
    check("rst_inflight", inflight, 2'd0);
    check("rst_frames", frames_done, 16'd0);
    check("rst_err", err, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_state", u_dut.state, SEQ_IDLE);
    check("rst_accept_disabled", src_accept, 1'b0);
    tick();
    reset_n = 1'b1;
    tick();

    // Test 1: one 28-row frame, last on row 28 only
    enable = 1'b1;
    send_frame("t1", 1'b0, 0);
    check("t1_inflight", inflight, 2'd1);
    check("t1_state", u_dut.state, SEQ_IDLE);
    check("t1_busy", busy, 1'b1);
    check("t1_frames", frames_done, 16'd0);

    // Test 2: second frame fills the pipe, results withheld
    send_frame("t2", 1'b0, 0);
    src_valid = 1'b1;
    #1;
    check("t2_state_full", u_dut.state, SEQ_FULL);
    check("t2_inflight", inflight, 2'd2);
    check("t2_accept_blocked", src_accept, 1'b0);
    check("t2_valid_blocked", cnn_valid, 1'b0);
    pulse_result();
    check("t2_frames_done", frames_done, 16'd1);
    check("t2_inflight_after", inflight, 2'd1);
    tick();
    check("t2_accept_reopen", src_accept, 1'b1);
    src_valid = 1'b0;

    // Test 3: commit and retire in the same cycle
    send_frame("t3", 1'b1, 0);
    check("t3_inflight_same", inflight, 2'd1);
    check("t3_frames", frames_done, 16'd2);
    check("t3_state", u_dut.state, SEQ_IDLE);
    check("t3_err", err, 1'b0);
    pulse_result();
    check("t3_drain_inflight", inflight, 2'd0);
    check("t3_drain_frames", frames_done, 16'd3);

    // Test 4: enable dropped after row 10 of an open frame
    send_frame("t4", 1'b0, 10);
    check("t4_inflight", inflight, 2'd1);
    src_valid = 1'b1;
    tick();
    tick();
    check("t4_blocked_valid", cnn_valid, 1'b0);
    check("t4_blocked_accept", src_accept, 1'b0);
    check("t4_state_idle", u_dut.state, SEQ_IDLE);
    enable = 1'b1;
    #1;
    check("t4_reenabled_valid", cnn_valid, 1'b1);
    src_valid = 1'b0;

    // Test 5: framing errors on the OUT_ROWS=2 instance
    enable2 = 1'b1; src_valid2 = 1'b1;
    tick();
    tick();
    src_valid2 = 1'b0;
    check("t5_inflight_commit", inflight2, 2'd1);
    res_valid2 = 1'b1; res_accept2 = 1'b1; res_last2 = 1'b1;
    tick();
    res_valid2 = 1'b0;
    check("t5_early_last_err", err2, 1'b1);
    check("t5_inflight_kept", inflight2, 2'd1);
    tick();
    check("t5_err_sticky", err2, 1'b1);
    err_clr2 = 1'b1;
    tick();
    err_clr2 = 1'b0;
    check("t5_err_cleared", err2, 1'b0);
    res_valid2 = 1'b1; res_last2 = 1'b1;
    tick();
    res_valid2 = 1'b0;
    check("t5_retire_ok_err", err2, 1'b0);
    check("t5_retire_inflight", inflight2, 2'd0);
    check("t5_retire_frames", frames_done2, 16'd1);
    res_valid2 = 1'b1; res_last2 = 1'b0;
    tick();
    res_valid2 = 1'b0;
    check("t5_underflow_err", err2, 1'b1);
    check("t5_underflow_inflight", inflight2, 2'd0);
    check("t5_underflow_frames", frames_done2, 16'd1);
    err_clr2 = 1'b1; res_valid2 = 1'b1;
    tick();
    err_clr2 = 1'b0; res_valid2 = 1'b0;
    check("t5_err_beats_clear", err2, 1'b1);

    // Test 6: asynchronous reset in the middle of a frame
    src_valid = 1'b1;
    for (int r = 1; r <= 15; r++) tick();
    check("t6_state_feed", u_dut.state, SEQ_FEED);
    src_valid = 1'b0;
    #3;
    reset_n = 1'b0;
    #1;
    check("t6_rst_inflight", inflight, 2'd0);
    check("t6_rst_frames", frames_done, 16'd0);
    check("t6_rst_busy", busy, 1'b0);
    check("t6_rst_last", cnn_last, 1'b0);
    check("t6_rst_state", u_dut.state, SEQ_IDLE);
    check("t6_rst_err2", err2, 1'b0);
    tick();
    reset_n = 1'b1;
    tick();
    send_frame("t6", 1'b0, 0);
    check("t6_inflight", inflight, 2'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
